// File: rtl/cc_demuxx_pkg.sv
// cc_pkg: selection and FSM encodings shared by the Collatz mux/demux blocks.
package cc_pkg;

   localparam logic [1:0] SEL_CH0  = 2'b00;
   localparam logic [1:0] SEL_CH1  = 2'b01;
   localparam logic [1:0] SEL_RSVD = 2'b10;
   localparam logic [1:0] SEL_DROP = 2'b11;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HOLD0 = 2'd1,
      HOLD1 = 2'd2
   } demuxState_t;

endpackage

// File: rtl/cc_demuxx_counter.sv
// cc_counter: wrapping up-counter with increment enable and synchronous active-low reset.
module cc_counter #(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rstN,
   input  logic             incEn,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rstN)
         count <= '0;
      else if (incEn)
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/cc_demuxx.sv
// cc_demuxx: registered 1-to-2 valid/ready demux with one-entry holding register and delivered-word counter.
// Define CC_DEMUX_DROP_COUNT_EN to add CC_DEMUX_dropCount_OutBUS counting accepted discard transfers.
module cc_demuxx
   import cc_pkg::*;
#(
   parameter int DATAWIDTH_MUX_SELECTION = 2,
   parameter int DATAWIDTH_BUS           = 8,
   parameter int DATAWIDTH_COUNT         = 16
)(
   input  logic                               CC_DEMUX_CLOCK_50,
   input  logic                               CC_DEMUX_RESET_InLow,
   input  logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data_InBUS,
   input  logic [DATAWIDTH_MUX_SELECTION-1:0] CC_DEMUX_selection_InBUS,
   input  logic                               CC_DEMUX_valid_In,
   output logic                               CC_DEMUX_ready_Out,
   output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data0_OutBUS,
   output logic                               CC_DEMUX_valid0_Out,
   input  logic                               CC_DEMUX_ready0_In,
   output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data1_OutBUS,
   output logic                               CC_DEMUX_valid1_Out,
   input  logic                               CC_DEMUX_ready1_In,
   output logic [DATAWIDTH_COUNT-1:0]         CC_DEMUX_count_OutBUS
`ifdef CC_DEMUX_DROP_COUNT_EN
   ,output logic [DATAWIDTH_COUNT-1:0]        CC_DEMUX_dropCount_OutBUS
`endif
);

   demuxState_t              state, stateNext;
   logic [DATAWIDTH_BUS-1:0] holdReg;
   logic                     inXfer, outXfer, loadWord, isDrop, isCh1;

   assign isDrop = CC_DEMUX_selection_InBUS == DATAWIDTH_MUX_SELECTION'(SEL_DROP);
   assign isCh1  = CC_DEMUX_selection_InBUS == DATAWIDTH_MUX_SELECTION'(SEL_CH1);

   // ready passes the target sink's ready through so a held word can be replaced in the same cycle
   always_comb begin
      CC_DEMUX_ready_Out    = CC_DEMUX_RESET_InLow & ((state == EMPTY) |
                              ((state == HOLD0) & CC_DEMUX_ready0_In) |
                              ((state == HOLD1) & CC_DEMUX_ready1_In));
      CC_DEMUX_valid0_Out   = state == HOLD0;
      CC_DEMUX_valid1_Out   = state == HOLD1;
      CC_DEMUX_data0_OutBUS = CC_DEMUX_valid0_Out ? holdReg : '0;
      CC_DEMUX_data1_OutBUS = CC_DEMUX_valid1_Out ? holdReg : '0;
      inXfer    = CC_DEMUX_valid_In & CC_DEMUX_ready_Out;
      outXfer   = (CC_DEMUX_valid0_Out & CC_DEMUX_ready0_In) | (CC_DEMUX_valid1_Out & CC_DEMUX_ready1_In);
      loadWord  = inXfer & ~isDrop;
      stateNext = inXfer ? (isDrop ? EMPTY : isCh1 ? HOLD1 : HOLD0) : outXfer ? EMPTY : state;
   end

   always_ff @(posedge CC_DEMUX_CLOCK_50) begin
      if (!CC_DEMUX_RESET_InLow) begin
         state   <= EMPTY;
         holdReg <= '0;
      end else begin
         state <= stateNext;
         if (loadWord)
            holdReg <= CC_DEMUX_data_InBUS;
      end
   end

   cc_counter #(.WIDTH(DATAWIDTH_COUNT)) deliveredCounter (
      .clk   (CC_DEMUX_CLOCK_50),
      .rstN  (CC_DEMUX_RESET_InLow),
      .incEn (outXfer),
      .count (CC_DEMUX_count_OutBUS)
   );

`ifdef CC_DEMUX_DROP_COUNT_EN
   cc_counter #(.WIDTH(DATAWIDTH_COUNT)) dropCounter (
      .clk   (CC_DEMUX_CLOCK_50),
      .rstN  (CC_DEMUX_RESET_InLow),
      .incEn (inXfer & isDrop),
      .count (CC_DEMUX_dropCount_OutBUS)
   );
`endif

endmodule

// File: tb/tb_cc_demuxx.sv
// tb_cc_demuxx: directed self-checking bench; a second instance with a 4-bit counter checks wrap.
module tb_cc_demuxx;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [7:0]  dataIn = '0;
   logic [1:0]  sel = '0;
   logic        validIn = 1'b0;
   logic        ready0 = 1'b0;
   logic        ready1 = 1'b0;
   logic        readyOut, valid0, valid1;
   logic [7:0]  data0, data1;
   logic [15:0] count;
   logic        sReadyOut, sValid0, sValid1;
   logic [7:0]  sData0, sData1;
   logic [3:0]  sCount;
`ifdef CC_DEMUX_DROP_COUNT_EN
   logic [15:0] dropCount;
   logic [3:0]  sDropCount;
`endif
   int checks = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cc_demuxx dut (
      .CC_DEMUX_CLOCK_50        (clk),
      .CC_DEMUX_RESET_InLow     (rstN),
      .CC_DEMUX_data_InBUS      (dataIn),
      .CC_DEMUX_selection_InBUS (sel),
      .CC_DEMUX_valid_In        (validIn),
      .CC_DEMUX_ready_Out       (readyOut),
      .CC_DEMUX_data0_OutBUS    (data0),
      .CC_DEMUX_valid0_Out      (valid0),
      .CC_DEMUX_ready0_In       (ready0),
      .CC_DEMUX_data1_OutBUS    (data1),
      .CC_DEMUX_valid1_Out      (valid1),
      .CC_DEMUX_ready1_In       (ready1),
      .CC_DEMUX_count_OutBUS    (count)
`ifdef CC_DEMUX_DROP_COUNT_EN
      ,.CC_DEMUX_dropCount_OutBUS (dropCount)
`endif
   );

   cc_demuxx #(.DATAWIDTH_COUNT(4)) dutSmall (
      .CC_DEMUX_CLOCK_50        (clk),
      .CC_DEMUX_RESET_InLow     (rstN),
      .CC_DEMUX_data_InBUS      (dataIn),
      .CC_DEMUX_selection_InBUS (sel),
      .CC_DEMUX_valid_In        (validIn),
      .CC_DEMUX_ready_Out       (sReadyOut),
      .CC_DEMUX_data0_OutBUS    (sData0),
      .CC_DEMUX_valid0_Out      (sValid0),
      .CC_DEMUX_ready0_In       (ready0),
      .CC_DEMUX_data1_OutBUS    (sData1),
      .CC_DEMUX_valid1_Out      (sValid1),
      .CC_DEMUX_ready1_In       (ready1),
      .CC_DEMUX_count_OutBUS    (sCount)
`ifdef CC_DEMUX_DROP_COUNT_EN
      ,.CC_DEMUX_dropCount_OutBUS (sDropCount)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstN = 1'b0; validIn = 1'b1; sel = 2'b00; dataIn = 8'hAA; ready0 = 1'b1; ready1 = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({readyOut, valid0, valid1, data0, data1, count} !== {3'b000, 8'h00, 8'h00, 16'h0000}) begin
         fails++;
         $display("FAIL reset_state: got rdy=%b v0=%b v1=%b d0=%h d1=%h cnt=%0d, expected all zero",
                  readyOut, valid0, valid1, data0, data1, count);
      end
      rstN = 1'b1; validIn = 1'b0;
      #1;
      checks++;
      if (readyOut !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready: got %b expected 1", readyOut);
      end
   endtask

   task automatic test_routing();
      tick();
      dataIn = 8'h1B; sel = 2'b01; validIn = 1'b1; ready1 = 1'b1;
      tick();
      validIn = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid1, data1, valid0, data0} !== {1'b1, 8'h1B, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL route_ch1: got v1=%b d1=%h v0=%b d0=%h expected v1=1 d1=1b v0=0 d0=00", valid1, data1, valid0, data0);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({count, valid1, readyOut} !== {16'd1, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL route_ch1_done: got cnt=%0d v1=%b rdy=%b expected cnt=1 v1=0 rdy=1", count, valid1, readyOut);
      end
      dataIn = 8'h05; sel = 2'b10; validIn = 1'b1; ready0 = 1'b1;
      tick();
      validIn = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid0, data0, valid1, data1} !== {1'b1, 8'h05, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL route_rsvd_ch0: got v0=%b d0=%h v1=%b d1=%h expected v0=1 d0=05 v1=0 d1=00", valid0, data0, valid1, data1);
      end
      tick();
      @(negedge clk);
      checks++;
      if (count !== 16'd2) begin
         fails++;
         $display("FAIL route_count: got %0d expected 2", count);
      end
   endtask

   task automatic test_backpressure();
      ready0 = 1'b0; dataIn = 8'h2A; sel = 2'b00; validIn = 1'b1;
      tick();
      validIn = 1'b0; dataIn = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({valid0, data0, readyOut} !== {1'b1, 8'h2A, 1'b0}) begin
            fails++;
            $display("FAIL backpressure_hold[%0d]: got v0=%b d0=%h rdy=%b expected v0=1 d0=2a rdy=0", i, valid0, data0, readyOut);
         end
         tick();
      end
      ready0 = 1'b1;
      #1;
      checks++;
      if ({readyOut, valid0} !== 2'b11) begin
         fails++;
         $display("FAIL backpressure_release: got rdy=%b v0=%b expected rdy=1 v0=1", readyOut, valid0);
      end
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({count, valid0} !== {16'd3, 1'b0}) begin
         fails++;
         $display("FAIL backpressure_once: got cnt=%0d v0=%b expected cnt=3 v0=0", count, valid0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  word;
      logic [18:0] expVec;
      ready0 = 1'b1; ready1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         word = 8'(i + 1);
         dataIn = word; sel = i[0] ? 2'b01 : 2'b00; validIn = 1'b1;
         tick();
         @(negedge clk);
         expVec = i[0] ? {1'b0, 1'b1, 8'h00, word, 1'b1} : {1'b1, 1'b0, word, 8'h00, 1'b1};
         checks++;
         if ({valid0, valid1, data0, data1, readyOut} !== expVec) begin
            fails++;
            $display("FAIL back_to_back[%0d]: got v0=%b v1=%b d0=%h d1=%h rdy=%b expected %h",
                     i, valid0, valid1, data0, data1, readyOut, expVec);
         end
      end
      validIn = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (count !== 16'd7) begin
         fails++;
         $display("FAIL back_to_back_count: got %0d expected 7", count);
      end
   endtask

   task automatic test_discard();
      dataIn = 8'h77; sel = 2'b11; validIn = 1'b1;
      tick();
      validIn = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid0, valid1, count, readyOut} !== {2'b00, 16'd7, 1'b1}) begin
         fails++;
         $display("FAIL discard_empty: got v0=%b v1=%b cnt=%0d rdy=%b expected v0=0 v1=0 cnt=7 rdy=1", valid0, valid1, count, readyOut);
      end
`ifdef CC_DEMUX_DROP_COUNT_EN
      checks++;
      if (dropCount !== 16'd1) begin
         fails++;
         $display("FAIL drop_count_1: got %0d expected 1", dropCount);
      end
`endif
      ready0 = 1'b0; dataIn = 8'h33; sel = 2'b00; validIn = 1'b1;
      tick();
      dataIn = 8'h99; sel = 2'b11;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({valid0, data0, readyOut} !== {1'b1, 8'h33, 1'b0}) begin
         fails++;
         $display("FAIL discard_while_hold: got v0=%b d0=%h rdy=%b expected v0=1 d0=33 rdy=0", valid0, data0, readyOut);
      end
      ready0 = 1'b1;
      tick();
      validIn = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid0, valid1, count} !== {2'b00, 16'd8}) begin
         fails++;
         $display("FAIL discard_with_delivery: got v0=%b v1=%b cnt=%0d expected v0=0 v1=0 cnt=8", valid0, valid1, count);
      end
`ifdef CC_DEMUX_DROP_COUNT_EN
      checks++;
      if (dropCount !== 16'd2) begin
         fails++;
         $display("FAIL drop_count_2: got %0d expected 2", dropCount);
      end
`endif
   endtask

   task automatic test_wrap();
      rstN = 1'b0;
      tick();
      rstN = 1'b1; ready1 = 1'b1; sel = 2'b01; validIn = 1'b1;
      for (int i = 0; i < 17; i++) begin
         dataIn = 8'(8'h40 + i);
         tick();
      end
      validIn = 1'b0;
      @(negedge clk);
      checks++;
      if ({count, sCount} !== {16'd16, 4'd0}) begin
         fails++;
         $display("FAIL wrap_16: got cnt=%0d small=%0d expected cnt=16 small=0", count, sCount);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({count, sCount} !== {16'd17, 4'd1}) begin
         fails++;
         $display("FAIL wrap_17: got cnt=%0d small=%0d expected cnt=17 small=1", count, sCount);
      end
   endtask

   task automatic test_reset_mid_hold();
      ready1 = 1'b0; dataIn = 8'hC3; sel = 2'b01; validIn = 1'b1;
      tick();
      validIn = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid1, data1} !== {1'b1, 8'hC3}) begin
         fails++;
         $display("FAIL mid_hold_setup: got v1=%b d1=%h expected v1=1 d1=c3", valid1, data1);
      end
      rstN = 1'b0;
      #1;
      checks++;
      if ({readyOut, count} !== {1'b0, 16'd17}) begin
         fails++;
         $display("FAIL mid_hold_pre_edge: got rdy=%b cnt=%0d expected rdy=0 cnt=17", readyOut, count);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({valid1, data1, count} !== {1'b0, 8'h00, 16'd0}) begin
         fails++;
         $display("FAIL mid_hold_reset: got v1=%b d1=%h cnt=%0d expected v1=0 d1=00 cnt=0", valid1, data1, count);
      end
      rstN = 1'b1; ready1 = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({valid1, count} !== {1'b0, 16'd0}) begin
         fails++;
         $display("FAIL mid_hold_dropped: got v1=%b cnt=%0d expected v1=0 cnt=0", valid1, count);
      end
   endtask

   initial begin
      test_reset();
      test_routing();
      test_backpressure();
      test_back_to_back();
      test_discard();
      test_wrap();
      test_reset_mid_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/cc_demuxx.md
Name: cc_demuxx

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the routing counterpart of the 2:1 selection mux in the Collatz datapath.
- Takes one word per accepted transfer from the Collatz step logic.
- Steers it to channel 0 (feedback into the iteration register) or channel 1 (result/test sink), or discards it.
- One-entry holding register with per-channel backpressure, plus a delivered-word counter.

Parameters:
- DATAWIDTH_MUX_SELECTION, 2, width of the selection bus (only encodings 00/01/10/11 defined).
- DATAWIDTH_BUS, 8, data word width.
- DATAWIDTH_COUNT, 16, width of the delivered-word counter.

Ports:
- CC_DEMUX_CLOCK_50  in  1  single clock, all state on rising edge.
- CC_DEMUX_RESET_InLow  in  1  synchronous, active-low reset.
- CC_DEMUX_data_InBUS  in  DATAWIDTH_BUS  incoming word.
- CC_DEMUX_selection_InBUS  in  DATAWIDTH_MUX_SELECTION  destination: 00 ch0, 01 ch1, 11 discard, 10 ch0.
- CC_DEMUX_valid_In  in  1  upstream word valid.
- CC_DEMUX_ready_Out  out  1  block can accept this cycle.
- CC_DEMUX_data0_OutBUS  out  DATAWIDTH_BUS  channel 0 word.
- CC_DEMUX_valid0_Out  out  1  channel 0 word valid.
- CC_DEMUX_ready0_In  in  1  channel 0 sink ready.
- CC_DEMUX_data1_OutBUS  out  DATAWIDTH_BUS  channel 1 word.
- CC_DEMUX_valid1_Out  out  1  channel 1 word valid.
- CC_DEMUX_ready1_In  in  1  channel 1 sink ready.
- CC_DEMUX_count_OutBUS  out  DATAWIDTH_COUNT  words delivered on either channel.

Behaviour:
- Interface: one clock, CC_DEMUX_CLOCK_50; reset CC_DEMUX_RESET_InLow is synchronous, active-low.
- Reset, sampled low at a clock edge: state EMPTY, holding register 0, both valid outputs 0, both data outputs 0, counter 0.
- While the reset input is low, ready_Out is forced to 0.
- Reset mid-transfer drops the held word silently; it is not delivered and not counted.
- Input transfer occurs when valid_In and ready_Out are both 1 at a rising edge. Output transfer on channel k occurs when validk_Out and readyk_In are both 1.
- FSM states: EMPTY, HOLD0, HOLD1.
  - EMPTY: ready_Out=1. Transfer with sel 00/10 -> HOLD0; sel 01 -> HOLD1; sel 11 -> discarded, stay EMPTY, register unchanged.
  - HOLDk: validk_Out=1, datak_OutBUS = holding register, the other channel's valid=0 and data=0. ready_Out = readyk_In (pass-through refill).
  - HOLDk on a channel-k transfer with no simultaneous input transfer -> EMPTY.
  - HOLDk on a channel-k transfer with a simultaneous input transfer -> load the new word and go to HOLD0/HOLD1 per its selection. Discard selection in this case -> EMPTY.
  - HOLDk with no channel-k transfer: hold register and valid stable; data must not change while valid is high.
- Latency: exactly 1 cycle from input transfer to validk_Out. Sustained throughput of 1 word/cycle when the target sink is always ready.
- Discard while holding: accepted only when ready_Out=1; the held word is unaffected unless simultaneously delivered.
- Counter: +1 per output transfer on either channel. Wraps modulo 2^DATAWIDTH_COUNT, from all-ones to 0 with no saturation. Discards are not counted.
- ready_Out is a combinational function of state, readyk_In and reset only. It never depends on valid_In.
- Selection and data are sampled only on an input transfer.

Optional Feature:
- Macro: CC_DEMUX_DROP_COUNT_EN.
- When defined: adds output port CC_DEMUX_dropCount_OutBUS (DATAWIDTH_COUNT). It counts accepted sel-11 transfers, wraps modulo 2^DATAWIDTH_COUNT, and resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cc_pkg holds:
  - selection encodings: SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_RSVD=2'b10, SEL_DROP=2'b11, shared with the existing mux;
  - FSM state encodings EMPTY/HOLD0/HOLD1.
- One natural sub-module: cc_counter, a synchronous active-low-reset wrapping up-counter with an increment enable.
  - Instanced once for the delivered count.
  - Instanced a second time under CC_DEMUX_DROP_COUNT_EN.

Test Plan:
- Reset: hold reset low 2 cycles with valid_In=1 -> ready_Out=0, valid0/1=0, data0/1=0, count=0; release -> ready_Out=1.
- Routing:
  - data 8'h1B, sel 01, ready1=1 -> next cycle valid1=1, data1=8'h1B, data0=0.
  - Following edge -> count=1, state EMPTY.
  - sel 10 with 8'h05 -> appears on ch0.
- Backpressure: ch0 word 8'h2A with ready0=0 for 5 cycles -> valid0 and data0=8'h2A stable, ready_Out=0. Raise ready0 -> delivered once, count +1.
- Back-to-back: 4 words 8'h01..8'h04 alternating sel 00/01, sinks always ready -> each appears 1 cycle after acceptance on the correct channel, ready_Out stays 1, count=4.
- Discard and wrap:
  - sel 11 word -> no valid asserted, count unchanged; dropCount=1 when the macro is defined.
  - With DATAWIDTH_COUNT=4, 17 deliveries -> count=1.
- Reset mid-hold: word held on ch1 with ready1=0, then assert reset -> next cycle valid1=0, count unchanged from pre-reset value and then 0.
